// File: rtl/tds_collector_pkg.sv
// tds_collector_pkg: shared header codes and channel-index width helper
package tds_collector_pkg;
    localparam logic [3:0] HDR_STRIP = 4'hF;
    localparam logic [3:0] HDR_PAD = 4'h0;
    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/tds_multi_channel_collector_if.sv
// tds_multi_channel_collector_if: per-channel decoder inputs and merged output stream
interface tds_multi_channel_collector_if import tds_collector_pkg::*; #(
    parameter int NUM_CH = 4,
    parameter int PAYLOAD_W = 116
) ();
    localparam int CH_W = ch_w(NUM_CH);
    logic [NUM_CH-1:0] tds_mode;
    logic [NUM_CH-1:0] linked;
    logic [NUM_CH-1:0] data_valid;
    logic [NUM_CH*PAYLOAD_W-1:0] data_in;
    logic out_ready;
    logic out_valid;
    logic [PAYLOAD_W+3:0] out_data;
    logic [CH_W-1:0] out_ch;
    modport master (
        output tds_mode, linked, data_valid, data_in, out_ready,
        input out_valid, out_data, out_ch
    );
    modport slave (
        input tds_mode, linked, data_valid, data_in, out_ready,
        output out_valid, out_data, out_ch
    );
endinterface

// File: rtl/tds_ch_fifo.sv
// tds_ch_fifo: show-ahead synchronous FIFO that accepts a push while full if a pop frees a slot
module tds_ch_fifo #(
    parameter int WIDTH = 120,
    parameter int DEPTH = 16
) (
    input  logic             clk_readout,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic do_push, do_pop;
    assign do_pop = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign empty = wr_ptr == rd_ptr;
    assign full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rdata = mem[rd_ptr[AW-1:0]];
    // storage needs no reset: the pointers decide which entries are live
    always_ff @(posedge clk_readout)
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    // pointer update, flush drops everything at once
    always_ff @(posedge clk_readout or posedge reset)
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
        end
endmodule

// File: rtl/tds_multi_channel_collector.sv
// tds_multi_channel_collector: buffers TDS channels and merges them round-robin into one stream
module tds_multi_channel_collector import tds_collector_pkg::*; #(
    parameter int NUM_CH = 4,
    parameter int PAYLOAD_W = 116,
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_W = 16
) (
    input  logic                    clk_readout,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    data_tran_stop,
    input  logic                    fifo_s_reset,
    input  logic                    cnt_clear,
    tds_multi_channel_collector_if.slave bus,
    output logic [NUM_CH-1:0]       ch_empty,
    output logic [NUM_CH-1:0]       overflow_flag,
    output logic [NUM_CH*CNT_W-1:0] drop_cnt,
    output logic [31:0]             word_cnt
);
    localparam int CH_W = ch_w(NUM_CH);
    localparam int DW = PAYLOAD_W + 4;
    logic [NUM_CH-1:0] push, pop, full, drop;
    logic [DW-1:0] rdata [NUM_CH];
    logic load, grant_valid;
    logic [CH_W-1:0] grant, ptr;
    logic [CH_W:0] idx;
    assign load = ~data_tran_stop & (~bus.out_valid | bus.out_ready) & ~fifo_s_reset;
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [CNT_W-1:0] cnt;
        logic ovf;
        assign push[i] = bus.data_valid[i] & bus.linked[i] & enable & ~fifo_s_reset;
        assign pop[i] = load & grant_valid & (grant == CH_W'(i));
        assign drop[i] = push[i] & full[i] & ~pop[i];
        assign drop_cnt[i*CNT_W +: CNT_W] = cnt;
        assign overflow_flag[i] = ovf;
        tds_ch_fifo #(.WIDTH(DW), .DEPTH(FIFO_DEPTH)) u_fifo (
            .clk_readout(clk_readout),
            .reset(reset),
            .flush(fifo_s_reset),
            .push(push[i]),
            .pop(pop[i]),
            .wdata({bus.tds_mode[i] ? HDR_STRIP : HDR_PAD, bus.data_in[i*PAYLOAD_W +: PAYLOAD_W]}),
            .rdata(rdata[i]),
            .full(full[i]),
            .empty(ch_empty[i])
        );
        // saturating drop count; a clear that coincides with a drop restarts at one
        always_ff @(posedge clk_readout or posedge reset)
            if (reset) begin
                cnt <= '0;
                ovf <= 1'b0;
            end else if (cnt_clear) begin
                cnt <= CNT_W'(drop[i]);
                ovf <= drop[i];
            end else if (drop[i]) begin
                if (~&cnt) cnt <= cnt + 1'b1;
                ovf <= 1'b1;
            end
    end
    // round-robin search: the non-empty channel at the smallest cyclic offset from ptr wins
    always_comb begin
        grant = '0;
        grant_valid = 1'b0;
        idx = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            idx = {1'b0, ptr} + (CH_W+1)'(k);
            if (idx >= (CH_W+1)'(NUM_CH)) idx = idx - (CH_W+1)'(NUM_CH);
            if (!ch_empty[idx[CH_W-1:0]]) begin
                grant = idx[CH_W-1:0];
                grant_valid = 1'b1;
            end
        end
    end
    // output stage: load a granted word, otherwise retire the held word on handshake
    always_ff @(posedge clk_readout or posedge reset)
        if (reset) begin
            bus.out_valid <= 1'b0;
            bus.out_data <= '0;
            bus.out_ch <= '0;
            ptr <= '0;
        end else if (fifo_s_reset) begin
            bus.out_valid <= 1'b0;
            ptr <= '0;
        end else if (load) begin
            bus.out_valid <= grant_valid;
            if (grant_valid) begin
                bus.out_data <= rdata[grant];
                bus.out_ch <= grant;
                ptr <= (grant == CH_W'(NUM_CH - 1)) ? '0 : grant + 1'b1;
            end
        end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
        end
    // delivered-word count, wraps naturally at 2^32
    always_ff @(posedge clk_readout or posedge reset)
        if (reset) word_cnt <= '0;
        else if (cnt_clear) word_cnt <= '0;
        else if (bus.out_valid & bus.out_ready) word_cnt <= word_cnt + 1'b1;
endmodule
